// File: rtl/quotient_bcd_conv_pkg.sv
// quotient_bcd_conv_pkg: shared FSM encoding, BCD constants and default widths
package quotient_bcd_conv_pkg;
  localparam int DEF_W = 26;
  localparam int DEF_DIGITS = 8;
  localparam logic [3:0] BCD_NINE = 4'h9;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/quotient_bcd_conv_if.sv
// quotient_bcd_conv_if: start/quotient request and BCD result bundle
interface quotient_bcd_conv_if
  import quotient_bcd_conv_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int DIGITS = DEF_DIGITS
);
  logic                  start;
  logic [W-1:0]          bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  bcd_valid;
  logic                  ovf;
  modport master (output start, bin, input bcd, busy, done, bcd_valid, ovf);
  modport slave (input start, bin, output bcd, busy, done, bcd_valid, ovf);
endinterface

// File: rtl/quotient_bcd_conv_add3.sv
// bcd_add3: one-digit correction step of shift-add-3, no carry out
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/quotient_bcd_conv.sv
// quotient_bcd_conv: sequential shift-add-3 binary-to-BCD converter for the divider quotient
module quotient_bcd_conv
  import quotient_bcd_conv_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic clk,
  input  logic rst_n,
  quotient_bcd_conv_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam int BW = 4 * DIGITS;
  state_t          state_q, state_d;
  logic            start_q;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [BW-1:0]   work_q, work_d, work_adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_s_q, ovf_s_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d, busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic            accept;
  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.d_i(work_q[4*g +: 4]), .d_o(work_adj[4*g +: 4]));
  end
  // a request is a fresh rising edge of start seen while idle; edges during a conversion are dropped
  assign accept = bus.start & ~start_q & (state_q == IDLE);
  // next-state and datapath: load on accept, one add-3/shift per cycle, publish result in DONE
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    work_d = work_q;
    cnt_d = cnt_q;
    ovf_s_d = ovf_s_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    busy_d = busy_q;
    done_d = 1'b0;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (accept) begin
        shreg_d = bus.bin;
        work_d = '0;
        cnt_d = '0;
        ovf_s_d = 1'b0;
        busy_d = 1'b1;
        valid_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        work_d = {work_adj[BW-2:0], shreg_q[W-1]};
        shreg_d = shreg_q << 1;
        ovf_s_d = ovf_s_q | work_adj[BW-1];
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(W - 1)) ? DONE : SHIFT;
      end
      DONE: begin
        bcd_d = ovf_s_q ? {DIGITS{BCD_NINE}} : work_q;
        ovf_d = ovf_s_q;
        done_d = 1'b1;
        valid_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; async reset aborts any conversion at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      shreg_q <= '0;
      work_q <= '0;
      cnt_q <= '0;
      ovf_s_q <= 1'b0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
      shreg_q <= shreg_d;
      work_q <= work_d;
      cnt_q <= cnt_d;
      ovf_s_q <= ovf_s_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
      valid_q <= valid_d;
    end
  end
  assign bus.bcd = bcd_q;
  assign bus.ovf = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd_valid = valid_q;
endmodule
